// File: rtl/img2col_scheduler.sv
// img2col_scheduler: walks a 5x5 window over an img_w x img_h image, steering the
// general/reuse/neighbour window banks and handing each assembled window to the PE array.
//
// Ports:
//   clk, nrst (sync, active-high)       clock and reset
//   start, abort                        begin a pass (IDLE only) / cancel a pass
//   in_valid, neighbour_in_flag         column-group memory handshake
//   out_ready                           PE array accepts the current window
//   wr_ctrl_*/r_ctrl_* (g, r, n)        bank write/read enables
//   adrs_out                            general-bank column slot being written
//   round                               1 while building the first window of a row
//   neighbour_out_flag, out_valid       window outputs valid
//   col_cnt, row_cnt                    window position
//   busy, done                          status / one-cycle completion pulse
module img2col_scheduler #(
    parameter int unsigned img_w       = 28,
    parameter int unsigned img_h       = 28,
    parameter int unsigned address_num = 3
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       in_valid,
    input  logic                       neighbour_in_flag,
    input  logic                       out_ready,
    output logic                       wr_ctrl_g,
    output logic                       r_ctrl_g,
    output logic                       wr_ctrl_r,
    output logic                       r_ctrl_r,
    output logic                       wr_ctrl_n,
    output logic                       r_ctrl_n,
    output logic [address_num-1:0]     adrs_out,
    output logic                       round,
    output logic                       neighbour_out_flag,
    output logic                       out_valid,
    output logic [$clog2(img_w)-1:0]   col_cnt,
    output logic [$clog2(img_h)-1:0]   row_cnt,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned col_w = $clog2(img_w);
    localparam int unsigned row_w = $clog2(img_h);

    localparam logic [col_w-1:0]       col_last  = col_w'(img_w - 5);
    localparam logic [row_w-1:0]       row_last  = row_w'(img_h - 5);
    localparam logic [address_num-1:0] adrs_last = address_num'(4);

    typedef enum logic [2:0] {StIdle, StLoad, StEmit, StShift, StDone} state_e;

    state_e                 state_q, state_d;
    logic [col_w-1:0]       col_d;
    logic [row_w-1:0]       row_d;
    logic [address_num-1:0] adrs_d;
    logic                   round_d;
    logic                   load_q;

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        col_d   = col_cnt;
        row_d   = row_cnt;
        adrs_d  = adrs_out;
        round_d = round;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    col_d   = '0;
                    row_d   = '0;
                    adrs_d  = '0;
                    round_d = 1'b1;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    // First window of a row needs all 5 columns; later windows need one.
                    if (!round || adrs_out == adrs_last) begin
                        state_d = StEmit;
                    end else begin
                        adrs_d = adrs_out + address_num'(1);
                    end
                end
            end
            StEmit: begin
                if (out_ready) state_d = StShift;
            end
            StShift: begin
                if (col_cnt < col_last) begin
                    col_d   = col_cnt + col_w'(1);
                    round_d = 1'b0;
                    state_d = StLoad;
                end else if (row_cnt < row_last) begin
                    row_d   = row_cnt + row_w'(1);
                    col_d   = '0;
                    round_d = 1'b1;
                    adrs_d  = '0;
                    state_d = StLoad;
                end else begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort && state_q != StIdle) begin
            state_d = StIdle;
            col_d   = '0;
            row_d   = '0;
            adrs_d  = '0;
            round_d = 1'b1;
        end
    end

    // State, counters and registered outputs, all decoded from the next state.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q            <= StIdle;
            col_cnt            <= '0;
            row_cnt            <= '0;
            adrs_out           <= '0;
            round              <= 1'b1;
            load_q             <= 1'b0;
            r_ctrl_g           <= 1'b0;
            wr_ctrl_r          <= 1'b0;
            r_ctrl_r           <= 1'b0;
            r_ctrl_n           <= 1'b0;
            neighbour_out_flag <= 1'b0;
            out_valid          <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
        end else begin
            state_q            <= state_d;
            col_cnt            <= col_d;
            row_cnt            <= row_d;
            adrs_out           <= adrs_d;
            round              <= round_d;
            load_q             <= (state_d == StLoad);
            // General bank is read during SHIFT too, to move columns into the reuse bank.
            r_ctrl_g           <= (state_d == StEmit) || (state_d == StShift);
            wr_ctrl_r          <= (state_d == StShift);
            r_ctrl_r           <= (state_d == StEmit);
            r_ctrl_n           <= (state_d == StEmit);
            neighbour_out_flag <= (state_d == StEmit);
            out_valid          <= (state_d == StEmit);
            busy               <= (state_d != StIdle);
            done               <= (state_d == StDone);
        end
    end

    // Write enables follow the column memory directly while loading.
    assign wr_ctrl_g = load_q & in_valid;
    assign wr_ctrl_n = load_q & in_valid & neighbour_in_flag;

endmodule

// File: tb/tb_img2col_scheduler.sv
// Scoreboard bench for img2col_scheduler on a 6x6 image (2x2 windows).
module tb_img2col_scheduler;

    localparam int unsigned IMG_W = 6;
    localparam int unsigned IMG_H = 6;
    localparam int unsigned AN    = 3;

    logic clk = 1'b0;
    logic nrst, start, abort, in_valid, neighbour_in_flag, out_ready;
    logic wr_ctrl_g, r_ctrl_g, wr_ctrl_r, r_ctrl_r, wr_ctrl_n, r_ctrl_n;
    logic [AN-1:0] adrs_out;
    logic round, neighbour_out_flag, out_valid, busy, done;
    logic [$clog2(IMG_W)-1:0] col_cnt;
    logic [$clog2(IMG_H)-1:0] row_cnt;

    img2col_scheduler #(.img_w(IMG_W), .img_h(IMG_H), .address_num(AN)) dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort), .in_valid(in_valid),
        .neighbour_in_flag(neighbour_in_flag), .out_ready(out_ready),
        .wr_ctrl_g(wr_ctrl_g), .r_ctrl_g(r_ctrl_g), .wr_ctrl_r(wr_ctrl_r),
        .r_ctrl_r(r_ctrl_r), .wr_ctrl_n(wr_ctrl_n), .r_ctrl_n(r_ctrl_n),
        .adrs_out(adrs_out), .round(round), .neighbour_out_flag(neighbour_out_flag),
        .out_valid(out_valid), .col_cnt(col_cnt), .row_cnt(row_cnt),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int col;
        int row;
        int cyc;   // cycle offset from start, or -1 when timing is not checked
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   base = 0;
    int   done_cnt = 0;
    int   last_done = -1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc - base);
        end
    endtask

    function automatic logic [9:0] flags();
        return {wr_ctrl_g, r_ctrl_g, wr_ctrl_r, r_ctrl_r, wr_ctrl_n, r_ctrl_n,
                neighbour_out_flag, out_valid, done, busy};
    endfunction

    // Monitor: pops the scoreboard on each accepted window, tracks done, checks bank exclusion.
    always @(negedge clk) begin
        if (!nrst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_window", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("win_col", int'(col_cnt), e.col);
                    check("win_row", int'(row_cnt), e.row);
                    if (e.cyc >= 0) check("win_cycle", cyc - base, e.cyc);
                end
            end
            if (done) begin
                done_cnt++;
                last_done = cyc;
            end
            check("bank_excl", int'((wr_ctrl_r & r_ctrl_r) | (wr_ctrl_n & r_ctrl_n) |
                                    (wr_ctrl_g & r_ctrl_g)), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        while (cyc < base + n) tick();
    endtask

    task automatic push_full(input bit timed, input int off);
        exp_q.push_back('{0, 0, timed ? 6 + off : -1});
        exp_q.push_back('{1, 0, timed ? 9 + off : -1});
        exp_q.push_back('{0, 1, timed ? 16 + off : -1});
        exp_q.push_back('{1, 1, timed ? 19 + off : -1});
    endtask

    task automatic run_start();
        base  = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits for the done pulse; returns in the cycle after DONE.
    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, done_cnt - d0, 1);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_flags"}, int'(flags()), 0);
        check({name, "_round"}, int'(round), 1);
        check({name, "_pos"}, int'({adrs_out, col_cnt, row_cnt}), 0);
    endtask

    initial begin
        int d0;
        nrst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        neighbour_in_flag = 1'b0; out_ready = 1'b0;
        tick(); tick();
        check_reset_vals("reset");
        nrst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check("idle_busy", int'(busy), 0);

        // Basic pass, with a start pulse while busy that must be ignored.
        push_full(1'b1, 0);
        run_start();
        check("load_adrs", int'(adrs_out), 0);
        check("load_round", int'(round), 1);
        check("load_busy_wrg", int'({busy, wr_ctrl_g, r_ctrl_g, r_ctrl_r}), 4'b1100);
        goto(3);
        start = 1'b1; tick(); start = 1'b0;
        wait_done("basic", 60);
        check("basic_done_cycle", last_done - base, 21);
        check("basic_after_done", int'({busy, done}), 0);

        // out_ready held low for the first 3 EMIT cycles.
        tick();
        push_full(1'b1, 3);
        run_start();
        goto(6);
        out_ready = 1'b0;
        for (int k = 6; k < 9; k++) begin
            check("stall_emit", int'({out_valid, neighbour_out_flag, r_ctrl_g, r_ctrl_r,
                                      r_ctrl_n, wr_ctrl_r}), 6'b111110);
            check("stall_pos", int'({col_cnt, row_cnt, round}), 1);
            tick();
        end
        out_ready = 1'b1;
        check("stall_accept_valid", int'(out_valid), 1);
        tick();
        check("stall_shift", int'({wr_ctrl_r, r_ctrl_g, out_valid, r_ctrl_r}), 4'b1100);
        wait_done("stall", 60);
        check("stall_done_cycle", last_done - base, 24);

        // in_valid toggling with neighbour data in the first LOAD.
        tick();
        push_full(1'b0, 0);
        neighbour_in_flag = 1'b1;
        run_start();
        for (int k = 1; k <= 9; k++) begin
            in_valid = k[0];
            #1;
            check("tog_wrg", int'(wr_ctrl_g), int'(k[0]));
            check("tog_wrn", int'(wr_ctrl_n), int'(k[0]));
            check("tog_adrs", int'(adrs_out), k / 2);
            check("tog_nflag_load", int'(neighbour_out_flag), 0);
            tick();
        end
        in_valid = 1'b1;
        check("tog_emit", int'({out_valid, neighbour_out_flag}), 2'b11);
        neighbour_in_flag = 1'b0;
        wait_done("toggle", 80);

        // abort in the second LOAD, then a fresh full pass.
        tick();
        exp_q.push_back('{0, 0, 6});
        run_start();
        goto(8);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_flags", int'(flags()), 0);
        d0 = done_cnt;
        repeat (5) tick();
        check("abort_no_done", done_cnt - d0, 0);
        push_full(1'b1, 0);
        run_start();
        wait_done("after_abort", 60);
        check("after_abort_done_cycle", last_done - base, 21);

        // Reset during the second EMIT; abort alone in IDLE; start+abort together.
        tick();
        exp_q.push_back('{0, 0, 6});
        run_start();
        goto(9);
        out_ready = 1'b0;
        check("pre_reset_emit", int'(out_valid), 1);
        nrst = 1'b1;
        tick();
        check_reset_vals("midpass_reset");
        nrst = 1'b0; out_ready = 1'b1;
        d0 = done_cnt;
        abort = 1'b1; tick(); abort = 1'b0;
        check("idle_abort_ignored", int'(busy), 0);
        tick();
        check("reset_no_done", done_cnt - d0, 0);
        push_full(1'b1, 0);
        base  = cyc;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_load", int'({busy, round, wr_ctrl_g}), 3'b111);
        wait_done("start_abort", 60);
        check("start_abort_done_cycle", last_done - base, 21);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/img2col_scheduler.md
IMG2COL_SCHEDULER -- requirements
Module: img2col_scheduler

Interface
REQ-001 Parameter img_w, default 28: input image width in pixels; must be at least 5.
REQ-002 Parameter img_h, default 28: input image height in pixels; must be at least 5.
REQ-003 Parameter address_num, default 3: width of the window column address.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 nrst  in  1  reset; synchronous, active-high (asserted = 1).
REQ-006 start  in  1  begin a full-image pass; sampled only in IDLE.
REQ-007 abort  in  1  cancel the pass in progress.
REQ-008 in_valid  in  1  the column-group memory presents a valid 5-pixel column this cycle.
REQ-009 neighbour_in_flag  in  1  the incoming column also carries neighbour-bank data.
REQ-010 out_ready  in  1  the PE array accepts the current window.
REQ-011 wr_ctrl_g, r_ctrl_g  out  1 each  write and read enables for the general bank.
REQ-012 wr_ctrl_r, r_ctrl_r  out  1 each  write and read enables for the reuse bank.
REQ-013 wr_ctrl_n, r_ctrl_n  out  1 each  write and read enables for the neighbour bank.
REQ-014 adrs_out  out  address_num  column slot (0..4) being written into the general bank.
REQ-015 round  out  1  1 while building the first window of a row, 0 otherwise.
REQ-016 neighbour_out_flag  out  1  the neighbour output is valid.
REQ-017 out_valid  out  1  the assembled 25-element window is valid.
REQ-018 col_cnt  out  $clog2(img_w)  window column index; row_cnt  out  $clog2(img_h)  window row index.
REQ-019 busy  out  1  high in every state except IDLE; done  out  1  one-cycle completion pulse.

Function
REQ-020 States SHALL be IDLE, LOAD, EMIT, SHIFT and DONE, one-hot or binary, with no other reachable states.
REQ-021 IDLE: all enables are 0; a start asserted in IDLE moves to LOAD with col_cnt=0, row_cnt=0, round=1 and adrs_out=0.
REQ-022 LOAD:
- wr_ctrl_g = in_valid.
- wr_ctrl_n = in_valid & neighbour_in_flag.
- No other enables are asserted.
- A stall (in_valid=0) holds the state and adrs_out.
REQ-023 LOAD with round=1: adrs_out increments 0→4 on each accepted column; the accepted write at adrs_out=4 moves to EMIT (5 accepted columns).
REQ-024 LOAD with round=0: adrs_out is held at 4; one accepted column moves to EMIT.
REQ-025 EMIT:
- out_valid, neighbour_out_flag, r_ctrl_g, r_ctrl_r and r_ctrl_n are all 1.
- The state holds until out_valid & out_ready, then moves to SHIFT.
- The outputs are stable while stalled.
REQ-026 SHIFT is exactly one cycle with wr_ctrl_r=1 and r_ctrl_g=1; all other enables are 0.
REQ-027 Exit from SHIFT:
- If col_cnt < img_w-5: col_cnt++, round=0, go to LOAD.
- Else if row_cnt < img_h-5: row_cnt++, col_cnt=0, round=1, adrs_out=0, go to LOAD.
- Else go to DONE.
REQ-028 DONE asserts done=1 for one cycle and then moves to IDLE; busy is 0 in the cycle after DONE.
REQ-029 Total windows emitted per pass SHALL be (img_w-4)*(img_h-4), in row-major order.
REQ-030 abort in any non-IDLE state SHALL move to IDLE on the next edge, with all enables 0 and no done pulse; abort in IDLE is ignored.
REQ-031 start asserted while busy SHALL be ignored; abort and start together in IDLE starts a pass.
REQ-032 Read enable and write enable of the same bank SHALL never both be 1, except that r_ctrl_g is allowed in SHIFT.
REQ-033 All outputs SHALL be registered or decoded from the registered state only (no input-to-output combinational path), except the enables gated by in_valid in LOAD.

Reset
REQ-034 While nrst=1 at a clock edge, the block SHALL enter IDLE with the following values:
- all enables, out_valid, neighbour_out_flag, done and busy = 0;
- adrs_out, col_cnt, row_cnt = 0;
- round = 1.
REQ-035 nrst asserted mid-pass SHALL override abort, start and all handshakes; no done pulse is produced.

Verification
REQ-036 img_w=6, img_h=6, in_valid=1, out_ready=1, start sampled at cycle 0 → out_valid in cycles 6, 9, 16 and 19; done at cycle 21; exactly 4 windows emitted.
REQ-037 Same configuration with out_ready=0 for 3 cycles at the first EMIT → EMIT held for 4 cycles with outputs stable; SHIFT follows the accepting cycle.
REQ-038 in_valid toggling 1,0,1,0 in the first LOAD → adrs_out advances only on the cycles with in_valid=1; wr_ctrl_g mirrors in_valid; EMIT is entered after the 5th accepted column.
REQ-039 neighbour_in_flag=1 during LOAD → wr_ctrl_n is 1 exactly on accepted cycles; neighbour_out_flag is 1 only in EMIT.
REQ-040 abort at cycle 8 of the 6x6 run → IDLE at cycle 9, all outputs 0, no done pulse; a new start then runs the full 4-window sequence.
REQ-041 nrst=1 during the second EMIT → the next edge gives all reset values; start pulsed during the pass → no effect.
